// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL divider configuration sequencer:
//   - default divider widths and the power-on divide ratio
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - counter width helper sized so a counter can hold its terminal value
package pll_ctrl_pkg;

   localparam int unsigned P_W_DEF   = 6;
   localparam int unsigned N_W_DEF   = 8;
   localparam int unsigned RATIO_DEF = 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_ACQUIRE = 3'd3;
   localparam logic [2:0] ST_LOCKED  = 3'd4;
   localparam logic [2:0] ST_FAIL    = 3'd5;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
   endfunction

endpackage

// File: rtl/ref_div_counter.sv
// ref_div_counter
// Programmable divide-by-N enable generator. Holds the applied ratio and a
// phase counter running 0..ratio-1; ref_en is high for the cycle in which the
// counter sits at ratio-1. A load pulse applies ratio_in (0 treated as 1) and
// forces the counter to 0, so the new ratio starts a fresh period on the
// following cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         apply ratio_in and restart the period
//   ratio_in     ratio to apply on load
//   ratio        currently applied ratio (registered)
//   ref_en       one-cycle pulse every ratio cycles (registered)
module ref_div_counter
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned W = P_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] ratio_in,
   output logic [W-1:0] ratio,
   output logic         ref_en
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;
   logic [W-1:0] ratio_nxt;

   // Next ratio and phase count; load restarts the period at 0.
   always_comb begin
      ratio_nxt = ratio;
      cnt_nxt   = cnt;
      if (load) begin
         ratio_nxt = (ratio_in == {W{1'b0}}) ? W'(RATIO_DEF) : ratio_in;
         cnt_nxt   = {W{1'b0}};
      end else if (cnt >= (ratio - W'(1))) begin
         cnt_nxt = {W{1'b0}};
      end else begin
         cnt_nxt = cnt + W'(1);
      end
   end

   // ref_en is registered from the next-cycle count so it lines up with cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio  <= W'(RATIO_DEF);
         cnt    <= {W{1'b0}};
         ref_en <= 1'b0;
      end else begin
         ratio  <= ratio_nxt;
         cnt    <= cnt_nxt;
         ref_en <= (cnt_nxt == (ratio_nxt - W'(1)));
      end
   end

endmodule

// File: rtl/pll_div_ctrl.sv
// pll_div_ctrl
// Configuration sequencer for the PLL pre-divider and feedback divider.
// Accepts a new ratio pair over valid/ready, applies it on a reference-enable
// boundary, holds the charge pump/VCO in reset while dividers settle, then
// watches PFD activity to declare lock, with timeout and bounded retry.
// Ports:
//   clk_in, rst_n     clock, asynchronous active-low reset
//   cfg_valid/ready   configuration handshake; cfg_p/cfg_n ratios (0 -> 1)
//   pd_up, pd_dn      PFD pulses, synchronous to clk_in
//   ref_en            divided reference enable (every div_p cycles)
//   div_p, div_n      applied pre-divide / feedback ratios
//   pll_rst_n         active-low reset to charge pump / VCO
//   locked, busy, err lock indication, sequencing in progress, lock failure
module pll_div_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned P_W         = P_W_DEF,
   parameter int unsigned N_W         = N_W_DEF,
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned LOCK_CNT    = 32,
   parameter int unsigned UNLOCK_CNT  = 4,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic           clk_in,
   input  logic           rst_n,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [P_W-1:0] cfg_p,
   input  logic [N_W-1:0] cfg_n,
   input  logic           pd_up,
   input  logic           pd_dn,
   output logic           ref_en,
   output logic [P_W-1:0] div_p,
   output logic [N_W-1:0] div_n,
   output logic           pll_rst_n,
   output logic           locked,
   output logic           busy,
   output logic           err
);

   localparam int unsigned SET_W = cnt_w(SETTLE_CYC);
   localparam int unsigned LCK_W = cnt_w(LOCK_CNT);
   localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYC);
   localparam int unsigned ACT_W = cnt_w(UNLOCK_CNT);
   localparam int unsigned RTY_W = cnt_w(MAX_RETRY);

   logic [2:0]     state,     state_nxt;
   logic [P_W-1:0] pend_p,    pend_p_nxt;
   logic [N_W-1:0] pend_n,    pend_n_nxt;
   logic [N_W-1:0] div_n_nxt;
   logic [SET_W-1:0] set_cnt, set_nxt;
   logic [LCK_W-1:0] quiet,   quiet_nxt, quiet_inc;
   logic [TMO_W-1:0] tmo,     tmo_nxt;
   logic [ACT_W-1:0] act,     act_nxt,   act_inc;
   logic [RTY_W-1:0] retry,   retry_nxt;
   logic           prst_nxt, locked_nxt, err_nxt, busy_nxt, ready_nxt;
   logic           accept, pd_act, load_div;

   assign accept    = cfg_valid & cfg_ready;
   assign pd_act    = pd_up | pd_dn;
   assign quiet_inc = quiet + LCK_W'(1);
   assign act_inc   = act + ACT_W'(1);

   ref_div_counter #(.W(P_W)) u_ref_div (
      .clk      (clk_in),
      .rst_n    (rst_n),
      .load     (load_div),
      .ratio_in (pend_p),
      .ratio    (div_p),
      .ref_en   (ref_en)
   );

   // Sequencer next-state and next-output logic.
   always_comb begin
      state_nxt  = state;
      pend_p_nxt = pend_p;
      pend_n_nxt = pend_n;
      div_n_nxt  = div_n;
      set_nxt    = set_cnt;
      quiet_nxt  = quiet;
      tmo_nxt    = tmo;
      act_nxt    = act;
      retry_nxt  = retry;
      prst_nxt   = pll_rst_n;
      locked_nxt = locked;
      err_nxt    = err;
      load_div   = 1'b0;

      case (state)
         ST_IDLE, ST_FAIL: begin
            state_nxt = state;
         end
         ST_LOAD: begin
            // Switch only on the last cycle of the old period.
            if (ref_en) begin
               load_div  = 1'b1;
               div_n_nxt = pend_n;
               set_nxt   = {SET_W{1'b0}};
               state_nxt = ST_SETTLE;
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         ST_SETTLE: begin
            if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
               prst_nxt  = 1'b1;
               tmo_nxt   = {TMO_W{1'b0}};
               quiet_nxt = {LCK_W{1'b0}};
               state_nxt = ST_ACQUIRE;
            end else begin
               set_nxt = set_cnt + SET_W'(1);
            end
         end
         ST_ACQUIRE: begin
            quiet_nxt = pd_act ? {LCK_W{1'b0}} : quiet_inc;
            // Lock is tested first so it wins over a coincident timeout.
            if (!pd_act && (quiet_inc == LCK_W'(LOCK_CNT))) begin
               locked_nxt = 1'b1;
               act_nxt    = {ACT_W{1'b0}};
               state_nxt  = ST_LOCKED;
            end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
               prst_nxt = 1'b0;
               if (retry < RTY_W'(MAX_RETRY)) begin
                  retry_nxt = retry + RTY_W'(1);
                  state_nxt = ST_LOAD;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_FAIL;
               end
            end else begin
               tmo_nxt = tmo + TMO_W'(1);
            end
         end
         ST_LOCKED: begin
            if (pd_act && (act_inc == ACT_W'(UNLOCK_CNT))) begin
               locked_nxt = 1'b0;
               tmo_nxt    = {TMO_W{1'b0}};
               quiet_nxt  = {LCK_W{1'b0}};
               act_nxt    = {ACT_W{1'b0}};
               state_nxt  = ST_ACQUIRE;
            end else begin
               act_nxt = pd_act ? act_inc : {ACT_W{1'b0}};
            end
         end
         default: begin
            prst_nxt   = 1'b0;
            locked_nxt = 1'b0;
            state_nxt  = ST_IDLE;
         end
      endcase

      // An accepted configuration overrides whatever the state decided.
      if (accept) begin
         pend_p_nxt = (cfg_p == {P_W{1'b0}}) ? P_W'(RATIO_DEF) : cfg_p;
         pend_n_nxt = (cfg_n == {N_W{1'b0}}) ? N_W'(RATIO_DEF) : cfg_n;
         retry_nxt  = {RTY_W{1'b0}};
         err_nxt    = 1'b0;
         locked_nxt = 1'b0;
         prst_nxt   = 1'b0;
         state_nxt  = ST_LOAD;
      end else begin
         pend_p_nxt = pend_p;
         pend_n_nxt = pend_n;
      end

      busy_nxt  = (state_nxt == ST_LOAD) || (state_nxt == ST_SETTLE) ||
                  (state_nxt == ST_ACQUIRE);
      ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_LOCKED) ||
                  (state_nxt == ST_FAIL);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pend_p    <= P_W'(RATIO_DEF);
         pend_n    <= N_W'(RATIO_DEF);
         div_n     <= N_W'(RATIO_DEF);
         set_cnt   <= {SET_W{1'b0}};
         quiet     <= {LCK_W{1'b0}};
         tmo       <= {TMO_W{1'b0}};
         act       <= {ACT_W{1'b0}};
         retry     <= {RTY_W{1'b0}};
         pll_rst_n <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend_p    <= pend_p_nxt;
         pend_n    <= pend_n_nxt;
         div_n     <= div_n_nxt;
         set_cnt   <= set_nxt;
         quiet     <= quiet_nxt;
         tmo       <= tmo_nxt;
         act       <= act_nxt;
         retry     <= retry_nxt;
         pll_rst_n <= prst_nxt;
         locked    <= locked_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
         cfg_ready <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_pll_div_ctrl.sv
// tb_pll_div_ctrl
// Directed bench for pll_div_ctrl: a table of {inputs, hold cycles, expected
// outputs} steps for the configure/settle/lock/unlock flow, followed by
// hand-written sequences for timeout retries, FAIL exit, reset during
// SETTLE and the zero-ratio case.
module tb_pll_div_ctrl;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [5:0] cfg_p;
   logic [7:0] cfg_n;
   logic       pd_up;
   logic       pd_dn;
   logic       ref_en;
   logic [5:0] div_p;
   logic [7:0] div_n;
   logic       pll_rst_n;
   logic       locked;
   logic       busy;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   pll_div_ctrl dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_p     (cfg_p),
      .cfg_n     (cfg_n),
      .pd_up     (pd_up),
      .pd_dn     (pd_dn),
      .ref_en    (ref_en),
      .div_p     (div_p),
      .div_n     (div_n),
      .pll_rst_n (pll_rst_n),
      .locked    (locked),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic       v;
      logic [5:0] p;
      logic [7:0] n;
      logic       up;
      logic       dn;
      int         cyc;
      logic       e_ref;
      logic [5:0] e_dp;
      logic [7:0] e_dn;
      logic       e_prst;
      logic       e_lock;
      logic       e_busy;
      logic       e_rdy;
      logic       e_err;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input vec_t x);
      check({tag, ".ref_en"},    {31'd0, ref_en},    {31'd0, x.e_ref});
      check({tag, ".div_p"},     {26'd0, div_p},     {26'd0, x.e_dp});
      check({tag, ".div_n"},     {24'd0, div_n},     {24'd0, x.e_dn});
      check({tag, ".pll_rst_n"}, {31'd0, pll_rst_n}, {31'd0, x.e_prst});
      check({tag, ".locked"},    {31'd0, locked},    {31'd0, x.e_lock});
      check({tag, ".busy"},      {31'd0, busy},      {31'd0, x.e_busy});
      check({tag, ".cfg_ready"}, {31'd0, cfg_ready}, {31'd0, x.e_rdy});
      check({tag, ".err"},       {31'd0, err},       {31'd0, x.e_err});
   endtask

   function automatic vec_t mk(input logic v, input logic [5:0] p, input logic [7:0] n,
                               input logic up, input logic dn, input int cyc,
                               input logic r, input logic [5:0] dp, input logic [7:0] dn_e,
                               input logic prst, input logic lk, input logic bz,
                               input logic rdy, input logic er);
      vec_t x;
      x.v = v; x.p = p; x.n = n; x.up = up; x.dn = dn; x.cyc = cyc;
      x.e_ref = r; x.e_dp = dp; x.e_dn = dn_e; x.e_prst = prst;
      x.e_lock = lk; x.e_busy = bz; x.e_rdy = rdy; x.e_err = er;
      return x;
   endfunction

   initial begin
      vec_t rst_exp;
      int   rise;
      int   falls;
      int   nref;
      logic prev_prst;
      logic done;

      //           v     p      n      up    dn   cyc  ref   dp    dn     prst  lock  busy  rdy   err
      vecs[0]  = mk(1'b0, 6'd0, 8'd0,  1'b0, 1'b0, 1,  1'b1, 6'd1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // first edge after reset
      vecs[1]  = mk(1'b0, 6'd0, 8'd0,  1'b0, 1'b0, 3,  1'b1, 6'd1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // ref_en every cycle
      vecs[2]  = mk(1'b1, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b1, 6'd1, 8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // accept -> LOAD
      vecs[3]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // load on ref_en (E0)
      vecs[4]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 15, 1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // E15 still settling
      vecs[5]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b0, 6'd3, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // E16 pll_rst_n rises
      vecs[6]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 31, 1'b1, 6'd3, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // E47 not yet locked
      vecs[7]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // E48 locked
      vecs[8]  = mk(1'b0, 6'd3, 8'd10, 1'b1, 1'b0, 3,  1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // 3 active: hold
      vecs[9]  = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // quiet clears
      vecs[10] = mk(1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 3,  1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // up&dn active x3
      vecs[11] = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b1, 1,  1'b1, 6'd3, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // 4th active: unlock
      vecs[12] = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 32, 1'b0, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // relock after 32
      vecs[13] = mk(1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1,  1'b1, 6'd3, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // phase cnt=2
      vecs[14] = mk(1'b1, 6'd5, 8'd20, 1'b0, 1'b0, 1,  1'b0, 6'd3, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // accept in LOCKED
      vecs[15] = mk(1'b1, 6'd7, 8'd7,  1'b0, 1'b0, 2,  1'b1, 6'd3, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // busy: cfg ignored
      vecs[16] = mk(1'b0, 6'd7, 8'd7,  1'b0, 1'b0, 1,  1'b0, 6'd5, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // old period done: load
      vecs[17] = mk(1'b0, 6'd7, 8'd7,  1'b0, 1'b0, 4,  1'b1, 6'd5, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // ref_en at count 4
      vecs[18] = mk(1'b0, 6'd7, 8'd7,  1'b0, 1'b0, 11, 1'b0, 6'd5, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // F15 settling
      vecs[19] = mk(1'b0, 6'd7, 8'd7,  1'b0, 1'b0, 1,  1'b0, 6'd5, 8'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // F16 release

      rst_exp = mk(1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 0, 1'b0, 6'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_p     = 6'd0;
      cfg_n     = 8'd0;
      pd_up     = 1'b0;
      pd_dn     = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check_outs("reset", rst_exp);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         cfg_valid = vecs[i].v;
         cfg_p     = vecs[i].p;
         cfg_n     = vecs[i].n;
         pd_up     = vecs[i].up;
         pd_dn     = vecs[i].dn;
         repeat (vecs[i].cyc) @(posedge clk_in);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i]);
      end

      // Toggling PFD never stays quiet long enough: 3 retries then FAIL.
      cfg_valid = 1'b0;
      pd_dn     = 1'b0;
      rise      = 0;
      falls     = 0;
      prev_prst = pll_rst_n;
      done      = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         pd_up = ((i >> 1) & 1) != 0;
         @(posedge clk_in);
         #1;
         if (prev_prst && !pll_rst_n) begin
            falls++;
            check($sformatf("acq_window%0d", falls), i + 1 - rise, 32'd4096);
            check($sformatf("err_at_fall%0d", falls), {31'd0, err}, (falls == 4) ? 32'd1 : 32'd0);
            check($sformatf("busy_at_fall%0d", falls), {31'd0, busy}, (falls < 4) ? 32'd1 : 32'd0);
            if (err) done = 1'b1;
         end else if (!prev_prst && pll_rst_n) begin
            rise = i + 1;
         end
         prev_prst = pll_rst_n;
      end
      pd_up = 1'b0;
      check("fail_reached", {31'd0, done}, 32'd1);
      check("fail_windows", falls, 32'd4);
      check("fail_ready", {31'd0, cfg_ready}, 32'd1);
      check("fail_locked", {31'd0, locked}, 32'd0);
      check("fail_prst", {31'd0, pll_rst_n}, 32'd0);

      // A new configuration leaves FAIL and clears err.
      cfg_valid = 1'b1;
      cfg_p     = 6'd9;
      cfg_n     = 8'd33;
      @(posedge clk_in);
      #1;
      cfg_valid = 1'b0;
      check("exit_err", {31'd0, err}, 32'd0);
      check("exit_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8 && div_p != 6'd9; i++) begin
         @(posedge clk_in);
         #1;
      end
      check("exit_div_p", {26'd0, div_p}, 32'd9);
      check("exit_div_n", {24'd0, div_n}, 32'd33);

      // Reset in the middle of SETTLE returns everything at once.
      repeat (5) @(posedge clk_in);
      #1;
      check("settle_prst", {31'd0, pll_rst_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_outs("midreset", rst_exp);
      #1;
      rst_n = 1'b1;
      nref  = 0;
      repeat (20) begin
         @(posedge clk_in);
         #1;
         nref += int'(ref_en);
      end
      check("post_rst_ref_count", nref, 32'd20);
      check("post_rst_div_p", {26'd0, div_p}, 32'd1);
      check("post_rst_div_n", {24'd0, div_n}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_prst", {31'd0, pll_rst_n}, 32'd0);
      check("post_rst_ready", {31'd0, cfg_ready}, 32'd1);

      // Zero ratios are applied as 1.
      cfg_valid = 1'b1;
      cfg_p     = 6'd0;
      cfg_n     = 8'd0;
      @(posedge clk_in);
      #1;
      cfg_valid = 1'b0;
      check("zero_accept_busy", {31'd0, busy}, 32'd1);
      @(posedge clk_in);
      #1;
      check("zero_div_p", {26'd0, div_p}, 32'd1);
      check("zero_div_n", {24'd0, div_n}, 32'd1);
      check("zero_ref_en", {31'd0, ref_en}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
